// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: multi-cycle unsigned WIDTH x WIDTH multiplier that returns the low WIDTH
// product bits. It works by shift-and-add and has no adder of its own. Every step it drives the
// shared combinational ALU and uses alu_out in the same cycle.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   start, a, b     operation request and operands; accepted only while ready=1
//   ready, busy     ready in IDLE/DONE, busy in STEP
//   done            one-cycle pulse when product/overflow hold a new result
//   product         low WIDTH bits of a*b, held until the next operation completes
//   overflow        set when the full unsigned product does not fit in WIDTH bits
//   alu_x, alu_y    ALU operands (accumulator, shifted multiplicand)
//   alu_ctrl        {za,na,zb,nb,f,no} to the ALU
//   alu_out         ALU result, combinational in the same cycle
module alu_mul_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             overflow,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [5:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_out
);

  localparam logic [5:0] CtrlZero = 6'b101010;  // ALU outputs constant 0
  localparam logic [5:0] CtrlAdd  = 6'b000010;  // ALU outputs x + y

  typedef enum logic [1:0] {StIdle, StStep, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic             overflow_q, overflow_d;
  logic             carry;
  logic             lost_bit;

  // Carry out of acc + mcand, recovered from the MSBs because the ALU exposes no carry flag.
  assign carry = (acc_q[WIDTH-1] & mcand_q[WIDTH-1]) |
                 ((acc_q[WIDTH-1] | mcand_q[WIDTH-1]) & ~alu_out[WIDTH-1]);

  // A set bit is about to leave the multiplicand while a later multiplier bit still needs it.
  assign lost_bit = mcand_q[WIDTH-1] & (mplier_q[WIDTH-1:1] != '0);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    product_d  = product_q;
    overflow_d = overflow_q;
    alu_ctrl   = CtrlZero;
    alu_x      = '0;
    alu_y      = '0;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = a;
          mplier_d = b;
          cnt_d    = '0;
          ovf_d    = 1'b0;
          state_d  = StStep;
        end else begin
          state_d = StIdle;
        end
      end
      StStep: begin
        alu_ctrl = CtrlAdd;
        alu_x    = acc_q;
        alu_y    = mcand_q;
        if (mplier_q[0]) begin
          acc_d = alu_out;
          if (carry) ovf_d = 1'b1;
        end
        if (lost_bit) ovf_d = 1'b1;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Always a full WIDTH steps, even once the multiplier has run out of set bits.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          product_d  = acc_d;
          overflow_d = ovf_d;
          state_d    = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      product_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      product_q  <= product_d;
      overflow_q <= overflow_d;
    end
  end

  assign ready    = (state_q == StIdle) || (state_q == StDone);
  assign busy     = (state_q == StStep);
  assign done     = (state_q == StDone);
  assign product  = product_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        ready, busy, done, overflow;
  logic [15:0] product, alu_x, alu_y, alu_out;
  logic [5:0]  alu_ctrl;

  always #5 clk = ~clk;

  // Hack-style ALU shared with the multiplier.
  function automatic logic [15:0] alu_f(input logic [15:0] x_in, input logic [15:0] y_in,
                                        input logic [5:0] c);
    logic [15:0] x, y, r;
    x = x_in;
    y = y_in;
    if (c[5]) x = '0;
    if (c[4]) x = ~x;
    if (c[3]) y = '0;
    if (c[2]) y = ~y;
    r = c[1] ? (x + y) : (x & y);
    if (c[0]) r = ~r;
    return r;
  endfunction

  assign alu_out = alu_f(alu_x, alu_y, alu_ctrl);

  alu_mul_sequencer #(.WIDTH(16), .CNT_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .overflow (overflow),
    .alu_x    (alu_x),
    .alu_y    (alu_y),
    .alu_ctrl (alu_ctrl),
    .alu_out  (alu_out)
  );

  // Scoreboard: the driver pushes (wr_ptr), the monitor pops (rd_ptr).
  typedef struct {
    logic [15:0] prod;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t sb [256];
  int   wr_ptr = 0;
  int   flush_ptr = 0;
  int   rd_ptr = 0;
  int   cyc = 0;
  int   busy_left = 0;   // cycles the accepted op still occupies the unit
  int   checks = 0;
  int   passes = 0;
  logic end_req = 1'b0;
  logic end_ack = 1'b0;
  logic [15:0] held_p = '0;
  logic        held_o = 1'b0;
  logic        exp_done;

  // Advance one clock and apply the reference model: an accepted op yields a*b
  // (low 16 bits, overflow when it exceeds 16 bits) 16 cycles after acceptance.
  task automatic tick();
    logic [31:0] p;
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      if (start && busy_left == 0) begin
        p = {16'd0, a} * {16'd0, b};
        if (wr_ptr < 256) sb[wr_ptr] = '{prod: p[15:0], ovf: (p[31:16] != 16'd0), due: cyc + 16};
        wr_ptr++;
        busy_left = 16;
      end else if (busy_left > 0) begin
        busy_left--;
      end
    end
    #1;
  endtask

  task automatic apply_reset(input int cycles);
    rst_n     = 1'b0;
    busy_left = 0;
    flush_ptr = wr_ptr;
    repeat (cycles) tick();
    rst_n = 1'b1;
  endtask

  task automatic issue(input logic [15:0] av, input logic [15:0] bv);
    a     = av;
    b     = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_status", {ready, busy, done, overflow, alu_ctrl}, {4'b1000, 6'b101010});
      chk("reset_product", product, 16'd0);
      held_p = '0;
      held_o = 1'b0;
      rd_ptr = flush_ptr;
    end else begin
      exp_done = (rd_ptr < wr_ptr) && (sb[rd_ptr].due == cyc);
      chk("done", done, exp_done);
      if (exp_done) begin
        held_p = sb[rd_ptr].prod;
        held_o = sb[rd_ptr].ovf;
        rd_ptr++;
      end
      chk("product", product, held_p);
      chk("overflow", overflow, held_o);
      chk("status", {ready, busy, alu_ctrl},
          {(busy_left == 0), (busy_left != 0), (busy_left != 0) ? 6'b000010 : 6'b101010});
      if (busy_left == 0) chk("alu_xy_idle", {alu_x, alu_y}, 32'd0);
    end
    if (end_req && !end_ack) begin
      chk("drain", rd_ptr, wr_ptr);
      end_ack = 1'b1;
    end
  end

  initial begin
    rst_n = 1'b1;
    #1;
    apply_reset(3);
    idle(2);

    // Basic 3*5.
    issue(16'd3, 16'd5);
    idle(18);

    // Boundary operands.
    issue(16'hFFFF, 16'd1);
    idle(17);
    issue(16'd256, 16'd256);
    idle(17);
    issue(16'h8000, 16'd2);
    idle(17);

    // Start while busy is ignored.
    issue(16'd7, 16'd9);
    idle(5);
    issue(16'd1, 16'd1);
    idle(14);

    // Reset mid-operation aborts with no done, then a fresh op.
    issue(16'd100, 16'd200);
    idle(8);
    apply_reset(2);
    idle(2);
    issue(16'd12, 16'd12);
    idle(18);

    // Start held across DONE: back-to-back ops, operands change while busy.
    a     = 16'd10;
    b     = 16'd10;
    start = 1'b1;
    tick();
    a = 16'd2;
    b = 16'd3;
    repeat (19) tick();
    start = 1'b0;
    idle(20);

    // Random traffic: random start pulses, some during busy, mixed operand ranges.
    repeat (500) begin
      start = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 0) begin
        a = 16'($urandom);
        b = 16'($urandom);
      end else begin
        a = 16'($urandom_range(0, 255));
        b = 16'($urandom_range(0, 255));
      end
      tick();
    end
    start = 1'b0;

    // Drain with a bounded wait, then let the monitor confirm the scoreboard is empty.
    for (int i = 0; i < 40 && busy_left != 0; i++) tick();
    idle(3);
    end_req = 1'b1;
    for (int i = 0; i < 5 && !end_ack; i++) @(posedge clk);
    if (!end_ack) $display("FAIL drain_handshake: got no ack expected ack");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
